// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for instruction fetch.
// The fetch unit's optional range check is enabled by INST_FETCH_RANGE_CHECK_EN.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_bus_t;

endpackage

// File: rtl/inst_fetch_if.sv
// ROM, redirect and fetch-to-decode signals of the fetch unit.
// fetch_err only exists when INST_FETCH_RANGE_CHECK_EN is defined.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 5
) ();

    logic              fetch_en;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst;
    logic              jbr_valid;
    logic [31:0]       jbr_target;
    logic              if_valid;
    logic              id_ready;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;
`ifdef INST_FETCH_RANGE_CHECK_EN
    logic              fetch_err;

    modport master (
        input  fetch_en, inst, jbr_valid, jbr_target, id_ready,
        output inst_addr, if_valid, if_pc, if_inst, fetch_err
    );

    modport slave (
        output fetch_en, inst, jbr_valid, jbr_target, id_ready,
        input  inst_addr, if_valid, if_pc, if_inst, fetch_err
    );
`else
    modport master (
        input  fetch_en, inst, jbr_valid, jbr_target, id_ready,
        output inst_addr, if_valid, if_pc, if_inst
    );

    modport slave (
        output fetch_en, inst, jbr_valid, jbr_target, id_ready,
        input  inst_addr, if_valid, if_pc, if_inst
    );
`endif

endinterface

// File: rtl/pc_reg.sv
// Program counter: redirect load beats +4 increment beats hold.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_target,
    input  logic        i_inc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: drives the ROM address, waits ROM_LAT cycles, holds {pc, inst}
// for decode. Optional out-of-range NOP substitution under INST_FETCH_RANGE_CHECK_EN.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ROM_DEPTH = 20,
    parameter int unsigned ROM_LAT   = 0
) (
    input logic         clk,
    input logic         reset,
    inst_fetch_if.master fetch_bus
);

    localparam logic [2:0] LAT = 3'(ROM_LAT);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end
    if (ROM_LAT > 7) begin : g_bad_rom_lat
        $error("ROM_LAT must be in 0..7");
    end
    if (ROM_DEPTH > (32'd1 << ADDR_W)) begin : g_bad_rom_depth
        $error("ROM_DEPTH exceeds the addressable ROM words");
    end

    fetch_state_e      r_state, w_state_d;
    logic [2:0]        r_cnt, w_cnt_d;
    logic              r_if_valid, w_if_valid_d;
    if_id_bus_t        r_if, w_if_d;
    logic [31:0]       w_pc;
    logic [31:0]       w_target;
    logic              w_pc_inc;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_inst_cap;

    assign w_addr   = w_pc[ADDR_W+1:2];
    assign w_target = fetch_bus.jbr_target & 32'hFFFF_FFFC;
    // pc_reg gives the redirect priority, so a same-cycle redirect suppresses this increment.
    assign w_pc_inc = (r_state == HOLD) && fetch_bus.id_ready;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (fetch_bus.jbr_valid),
        .i_target (w_target),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

`ifdef INST_FETCH_RANGE_CHECK_EN
    logic w_out_of_range;
    logic r_fetch_err, w_fetch_err_d;

    assign w_out_of_range = ({{(32-ADDR_W){1'b0}}, w_addr} >= ROM_DEPTH);
    assign w_inst_cap     = w_out_of_range ? NOP_INST : fetch_bus.inst;
`else
    assign w_inst_cap = fetch_bus.inst;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_if_valid_d = r_if_valid;
        w_if_d       = r_if;
`ifdef INST_FETCH_RANGE_CHECK_EN
        w_fetch_err_d = r_fetch_err;
`endif
        unique case (r_state)
            IDLE: begin
                if (fetch_bus.fetch_en) begin
                    w_state_d = FETCH;
                    w_cnt_d   = '0;
                end
            end
            FETCH: begin
                if (fetch_bus.jbr_valid) begin
                    w_cnt_d = '0;
                end else if (r_cnt == LAT) begin
                    w_if_d.pc    = w_pc;
                    w_if_d.inst  = w_inst_cap;
                    w_if_valid_d = 1'b1;
                    w_state_d    = HOLD;
`ifdef INST_FETCH_RANGE_CHECK_EN
                    w_fetch_err_d = w_out_of_range;
`endif
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            HOLD: begin
                if (fetch_bus.jbr_valid || fetch_bus.id_ready) begin
                    w_if_valid_d = 1'b0;
                    w_cnt_d      = '0;
                    w_state_d    = fetch_bus.fetch_en ? FETCH : IDLE;
`ifdef INST_FETCH_RANGE_CHECK_EN
                    w_fetch_err_d = 1'b0;
`endif
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_if_valid <= 1'b0;
            r_if       <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_if_valid <= w_if_valid_d;
            r_if       <= w_if_d;
        end
    end

`ifdef INST_FETCH_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_fetch_err_d;
        end
    end

    assign fetch_bus.fetch_err = r_fetch_err;
`endif

    assign fetch_bus.inst_addr = w_addr;
    assign fetch_bus.if_valid  = r_if_valid;
    assign fetch_bus.if_pc     = r_if.pc;
    assign fetch_bus.if_inst   = r_if.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: ROM_LAT=0 and ROM_LAT=3 instances on shared stimulus, checked against a
// transaction-level model. Build with INST_FETCH_RANGE_CHECK_EN to cover the range-check feature.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef INST_FETCH_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        jbr_valid;
    logic [31:0] jbr_target;
    logic        id_ready;
    logic [31:0] rom [32];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: next PC, whether a fetch is in flight and its remaining wait, and the held word.
    logic [31:0] m_pc [2];
    bit          m_fetching [2];
    int          m_remaining [2];
    bit          m_held [2];
    logic [31:0] m_hpc [2];
    logic [31:0] m_hinst [2];
    bit          m_err [2];

    logic        obs_valid [2];
    logic [31:0] obs_pc [2];
    logic [31:0] obs_inst [2];
    logic [4:0]  obs_addr [2];

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(5)) bus0 ();
    inst_fetch_if #(.ADDR_W(5)) bus3 ();

    assign bus0.fetch_en   = fetch_en;
    assign bus0.jbr_valid  = jbr_valid;
    assign bus0.jbr_target = jbr_target;
    assign bus0.id_ready   = id_ready;
    assign bus0.inst       = rom[bus0.inst_addr];
    assign bus3.fetch_en   = fetch_en;
    assign bus3.jbr_valid  = jbr_valid;
    assign bus3.jbr_target = jbr_target;
    assign bus3.id_ready   = id_ready;
    assign bus3.inst       = rom[bus3.inst_addr];

    assign obs_valid[0] = bus0.if_valid;
    assign obs_pc[0]    = bus0.if_pc;
    assign obs_inst[0]  = bus0.if_inst;
    assign obs_addr[0]  = bus0.inst_addr;
    assign obs_valid[1] = bus3.if_valid;
    assign obs_pc[1]    = bus3.if_pc;
    assign obs_inst[1]  = bus3.if_inst;
    assign obs_addr[1]  = bus3.inst_addr;

`ifdef INST_FETCH_RANGE_CHECK_EN
    logic obs_err [2];
    assign obs_err[0] = bus0.fetch_err;
    assign obs_err[1] = bus3.fetch_err;
`endif

    inst_fetch #(
        .RESET_PC (RST_PC), .ADDR_W (5), .ROM_DEPTH (20), .ROM_LAT (0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bus0.master)
    );

    inst_fetch #(
        .RESET_PC (RST_PC), .ADDR_W (5), .ROM_DEPTH (20), .ROM_LAT (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bus3.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock using the inputs that are about to be sampled.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          lat;
            logic [31:0] tgt;
            logic [4:0]  a;
            lat = (k == 0) ? 0 : 3;
            tgt = {jbr_target[31:2], 2'b00};
            a   = m_pc[k][6:2];
            if (reset) begin
                m_pc[k] = RST_PC;  m_fetching[k] = 0; m_remaining[k] = 0;
                m_held[k] = 0;     m_hpc[k] = '0;     m_hinst[k] = '0; m_err[k] = 0;
            end else if (m_held[k]) begin
                if (jbr_valid || id_ready) begin
                    m_held[k]      = 0;
                    m_err[k]       = 0;
                    m_pc[k]        = jbr_valid ? tgt : m_pc[k] + 32'd4;
                    m_fetching[k]  = fetch_en;
                    m_remaining[k] = lat;
                end
            end else if (m_fetching[k]) begin
                if (jbr_valid) begin
                    m_pc[k]        = tgt;
                    m_remaining[k] = lat;
                end else if (m_remaining[k] == 0) begin
                    m_hpc[k]      = m_pc[k];
                    m_err[k]      = RANGE_CHK && (a >= 5'd20);
                    m_hinst[k]    = m_err[k] ? 32'h0 : rom[a];
                    m_held[k]     = 1;
                    m_fetching[k] = 0;
                end else begin
                    m_remaining[k]--;
                end
            end else begin
                if (jbr_valid) m_pc[k] = tgt;
                if (fetch_en) begin
                    m_fetching[k]  = 1;
                    m_remaining[k] = lat;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_valid", k), 32'(obs_valid[k]), 32'(m_held[k]));
            check($sformatf("dut%0d_addr", k), 32'(obs_addr[k]), 32'(m_pc[k][6:2]));
            check($sformatf("dut%0d_pc", k), obs_pc[k], m_hpc[k]);
            check($sformatf("dut%0d_inst", k), obs_inst[k], m_hinst[k]);
`ifdef INST_FETCH_RANGE_CHECK_EN
            check($sformatf("dut%0d_err", k), 32'(obs_err[k]), 32'(m_err[k]));
`endif
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rom[i] = $urandom();
        rom[0]  = 32'h2401_0001;
        rom[1]  = 32'h0001_1100;
        rom[2]  = 32'h0041_1821;
        rom[3]  = 32'h0002_2082;
        rom[13] = 32'h8C2A_0013;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_fetching[k] = 0; m_remaining[k] = 0;
            m_held[k] = 0; m_hpc[k] = '0; m_hinst[k] = '0; m_err[k] = 0;
        end
        reset = 1'b1; fetch_en = 1'b0; id_ready = 1'b0; jbr_valid = 1'b0; jbr_target = '0;
        @(negedge clk);
        cycle(); cycle();
        check("rst_valid", 32'(obs_valid[0]), 32'h0);
        check("rst_if_pc", obs_pc[0], 32'h0);
        check("rst_if_inst", obs_inst[0], 32'h0);
        check("rst_addr", 32'(obs_addr[0]), 32'h0);

        // Back-to-back fetch with decode always ready.
        reset = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
        cycle();
        check("lat0_not_yet", 32'(obs_valid[0]), 32'h0);
        cycle();
        check("first_valid", 32'(obs_valid[0]), 32'h1);
        check("first_pc", obs_pc[0], 32'h00);
        check("first_inst", obs_inst[0], 32'h2401_0001);
        cycle(); cycle();
        check("second_pc", obs_pc[0], 32'h04);
        check("second_inst", obs_inst[0], 32'h0001_1100);

        // Decode stalls while 0x08 is held.
        cycle();
        id_ready = 1'b0;
        cycle();
        repeat (5) cycle();
        check("stall_valid", 32'(obs_valid[0]), 32'h1);
        check("stall_pc", obs_pc[0], 32'h08);
        check("stall_inst", obs_inst[0], 32'h0041_1821);
        check("stall_addr", 32'(obs_addr[0]), 32'd2);
        id_ready = 1'b1;
        cycle(); cycle();
        check("after_stall_pc", obs_pc[0], 32'h0C);
        check("after_stall_inst", obs_inst[0], 32'h0002_2082);

        // Redirect beats a same-cycle handshake.
        jbr_valid = 1'b1; jbr_target = 32'h30;
        cycle();
        jbr_valid = 1'b0; id_ready = 1'b0;
        cycle();
        check("hold_30", obs_pc[0], 32'h30);
        jbr_valid = 1'b1; jbr_target = 32'h34; id_ready = 1'b1;
        cycle();
        check("flush_valid", 32'(obs_valid[0]), 32'h0);
        check("flush_addr", 32'(obs_addr[0]), 32'd13);
        jbr_valid = 1'b0; id_ready = 1'b0;
        cycle();
        check("redir_pc", obs_pc[0], 32'h34);
        check("redir_inst", obs_inst[0], 32'h8C2A_0013);

        // Target low bits are dropped.
        jbr_valid = 1'b1; jbr_target = 32'h37;
        cycle();
        check("lowbits_addr", 32'(obs_addr[0]), 32'd13);
        jbr_valid = 1'b0;
        cycle();
        check("lowbits_pc", obs_pc[0], 32'h34);

        // Reset while holding.
        reset = 1'b1;
        cycle();
        check("midrst_valid", 32'(obs_valid[0]), 32'h0);
        check("midrst_addr", 32'(obs_addr[0]), 32'h0);
        reset = 1'b0; fetch_en = 1'b0;
        cycle();
        check("idle_stays", 32'(obs_valid[0]), 32'h0);

        // ROM_LAT=3: count edges from entering FETCH to if_valid.
        fetch_en = 1'b1;
        cycle();
        n = 0;
        while (!obs_valid[1] && n < 20) begin
            cycle();
            n++;
        end
        check("lat3_rise", 32'(n), 32'd4);

        // Sequential fetch past the last implemented word.
        reset = 1'b1; fetch_en = 1'b0;
        cycle();
        reset = 1'b0; jbr_valid = 1'b1; jbr_target = 32'h48;
        cycle();
        jbr_valid = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
        repeat (6) cycle();
        check("range_pc", obs_pc[0], 32'h50);
        check("range_addr", 32'(obs_addr[0]), 32'd20);
`ifdef INST_FETCH_RANGE_CHECK_EN
        check("range_inst", obs_inst[0], 32'h0);
        check("range_err", 32'(obs_err[0]), 32'h1);
`else
        check("range_inst", obs_inst[0], rom[20]);
`endif

        // PC wraps modulo 2^32.
        jbr_valid = 1'b1; jbr_target = 32'hFFFF_FFFF; id_ready = 1'b0;
        cycle();
        jbr_valid = 1'b0;
        cycle();
        check("wrap_hold_pc", obs_pc[0], 32'hFFFF_FFFC);
        id_ready = 1'b1;
        cycle();
        check("wrap_addr", 32'(obs_addr[0]), 32'h0);
        cycle();
        check("wrap_pc", obs_pc[0], 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(99) == 0);
            fetch_en  = ($urandom_range(7) != 0);
            id_ready  = ($urandom_range(2) != 0);
            jbr_valid = ($urandom_range(7) == 0);
            case ($urandom_range(2))
                0:       jbr_target = $urandom_range(127);
                1:       jbr_target = 32'hFFFF_FFF0 | $urandom_range(15);
                default: jbr_target = $urandom();
            endcase
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator for the single-issue teaching CPU. It is the requesting side of the asynchronous instruction ROM.
- Owns the PC and drives the ROM word address. It waits a configurable number of cycles, captures the returned instruction and hands {pc, inst} to decode over a valid/ready handshake.
- Accepts jump/branch redirects from execute, which flush any in-flight or held fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 5, ROM word-address width; inst_addr = pc[ADDR_W+1:2].
- ROM_DEPTH, 20, number of implemented ROM words; used only by the optional feature.
- ROM_LAT, 0, extra wait cycles before sampling inst (0 = async ROM; range 0..7).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  level; 1 = fetching permitted, 0 = stay in or return to IDLE after the current handshake.
- inst_addr  out  ADDR_W  ROM word address, combinational from pc.
- inst  in  32  ROM read data.
- jbr_valid  in  1  one-cycle redirect pulse from execute.
- jbr_target  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- if_valid  out  1  {if_pc, if_inst} is valid for decode.
- id_ready  in  1  decode accepts this cycle.
- if_pc  out  32  PC of the held instruction.
- if_inst  out  32  held instruction word.

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, wait counter=0, if_valid=0, if_pc=0, if_inst=0. Reset wins over every other input.
- States are IDLE, FETCH and HOLD.
- IDLE:
  - if_valid=0.
  - fetch_en=1 -> FETCH, counter cleared.
  - jbr_valid updates pc; state stays IDLE.
- FETCH:
  - The counter runs from 0 to ROM_LAT.
  - On the cycle where counter==ROM_LAT: if_inst<=inst, if_pc<=pc, if_valid<=1, go to HOLD.
  - With ROM_LAT=0, if_valid rises 1 cycle after entering FETCH.
- HOLD:
  - if_valid=1; if_pc and if_inst stay stable until the handshake.
  - Handshake is if_valid&id_ready. On handshake: pc<=pc+4, if_valid<=0.
  - After the handshake, fetch_en=1 -> FETCH, otherwise IDLE.
  - Throughput with ROM_LAT=0: one instruction every 2 cycles.
- Redirect (jbr_valid=1, in any state):
  - pc<={jbr_target[31:2],2'b00}.
  - In FETCH: the counter restarts and the current fetch is discarded.
  - In HOLD: if_valid<=0 (held instruction flushed) and state goes to FETCH if fetch_en=1, else IDLE. This applies even if id_ready=1 in the same cycle: the redirect wins, nothing is handed off, and there is no pc+4.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
  - inst_addr takes only pc[ADDR_W+1:2], so the ROM view aliases every 128 bytes.
- fetch_en falling in FETCH: the in-flight fetch completes to HOLD; the block idles after that handshake.

Optional Feature:
- Macro: INST_FETCH_RANGE_CHECK_EN.
- When defined:
  - Adds output fetch_err (1 bit, reset 0).
  - In FETCH, if pc[ADDR_W+1:2] >= ROM_DEPTH, then if_inst<=32'h0000_0000 (sll $0 NOP) and fetch_err<=1 alongside if_valid.
  - fetch_err clears with if_valid (handshake, redirect or reset).
- When undefined: no fetch_err port; out-of-range addresses return whatever the ROM drives.

Decomposition:
- Shared package cpu_pkg holds:
  - Fetch state enum {IDLE, FETCH, HOLD}.
  - RESET_PC default and NOP_INST = 32'h0.
  - if_id_bus_t struct {pc[31:0], inst[31:0]}.
- One natural sub-module, pc_reg: PC register with reset, +4 increment and redirect-load priority (redirect > increment > hold).
- The FSM and wait counter stay in inst_fetch.

Test Plan:
- Reset, then fetch_en=1, id_ready=1, ROM_LAT=0 -> if_valid rises 1 cycle after FETCH with if_pc=0x00, if_inst=0x24010001; next handshake gives if_pc=0x04, if_inst=0x00011100.
- id_ready=0 for 5 cycles while holding pc 0x08 -> if_inst stays 0x00411821 and pc stays 0x08; on release the next fetch is 0x0C, 0x00022082.
- jbr_valid with target 0x34 during HOLD at 0x30, with id_ready=1 the same cycle -> 0x30 is never handed off; next if_pc=0x34, if_inst=0x8C2A0013.
- jbr_target=0x37 -> pc=0x34 (low bits cleared); ROM_LAT=3 -> if_valid 4 cycles after entering FETCH.
- INST_FETCH_RANGE_CHECK_EN defined, sequential fetch past 0x4C to 0x50 -> if_inst=0, fetch_err=1; without the macro, inst_addr=20 and the ROM data passes through.
- reset asserted mid-HOLD -> next cycle if_valid=0, pc=RESET_PC, state IDLE.
